trace_cmd_queue: RTL and testbench
==================================

TRACE_CMD_QUEUE -- requirements
Module: trace_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries (power of two, 2..16).
REQ-002 Parameter CNT_W, default 32, width of every statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instruction_ready  input  1  one-cycle strobe, trace record present on n/address/mode.
REQ-006 n  input  32  trace command code (int).
REQ-007 address  input  32  trace byte address.
REQ-008 mode  input  32  print mode; bit 0 used, bits 31:1 ignored.
REQ-009 in_ready  output  1  FIFO can accept a record this cycle.
REQ-010 cmd_valid  output  1  head entry presented to cache.
REQ-011 cmd_ready  input  1  cache accepts head entry.
REQ-012 cmd_op  output  3  decoded op (package enum).
REQ-013 cmd_tag / cmd_index / cmd_offset  output  12/14/6  address fields, 31:20 / 19:6 / 5:0.
REQ-014 cmd_verbose  output  1  captured mode bit 0.
REQ-015 instr_reads, data_reads, data_writes, drop_cnt  output  CNT_W  statistics.
REQ-016 bad_cmd, overflow  output  1  one-cycle error pulses.

Function
REQ-017 Decode: n=0 OP_DREAD, 1 OP_DWRITE, 2 OP_IFETCH, 3 OP_INVAL, 4 OP_SNOOP, 8 OP_CLEAR, 9 OP_PRINT; all other values illegal.
REQ-018 in_ready SHALL equal NOT full, registered-state derived, no combinational path from cmd_ready.
REQ-019 Accept = instruction_ready AND in_ready AND legal n; entry {op, address, mode[0]} written at that edge.
REQ-020 Illegal n with instruction_ready: not enqueued, bad_cmd pulses next cycle, drop_cnt +1.
REQ-021 instruction_ready while full (legal n): record dropped, overflow pulses next cycle, drop_cnt +1.
REQ-022 Latency: record accepted at edge t into empty FIFO drives cmd_valid high after edge t (cycle t+1).
REQ-023 cmd_valid = NOT empty; head outputs stable while cmd_valid high and cmd_ready low.
REQ-024 Dequeue on cmd_valid AND cmd_ready; next entry presented the following cycle without a bubble.
REQ-025 Simultaneous accept and dequeue when not full: occupancy unchanged, order preserved; when full, no accept (REQ-021).
REQ-026 Read/write pointers wrap modulo DEPTH; occupancy counter 0..DEPTH distinguishes full from empty.
REQ-027 Counters increment at accept: OP_IFETCH -> instr_reads, OP_DREAD -> data_reads, OP_DWRITE -> data_writes; other ops none.
REQ-028 Accepted OP_CLEAR zeroes instr_reads, data_reads, data_writes, drop_cnt at the same edge; FIFO contents kept, OP_CLEAR still enqueued for the cache.
REQ-029 All counters saturate at all-ones.
REQ-030 OP_PRINT and OP_CLEAR address fields forwarded unchanged (don't-care to cache).

Reset
REQ-031 reset SHALL dominate all inputs in that cycle, including instruction_ready.
REQ-032 After reset: FIFO empty, pointers 0, cmd_valid 0, in_ready 1, all counters 0, bad_cmd 0, overflow 0, cmd_op OP_DREAD, address fields 0, cmd_verbose 0.
REQ-033 Reset mid-operation discards all queued entries; no partial dequeue is reported.

Structure
REQ-034 Shared package holds op enum (3-bit), command code constants 0-4/8/9, and TAG_W=12, INDEX_W=14, OFFSET_W=6, shared with L1_Cache.
REQ-035 One sub-module: cmd_fifo (parameterized DEPTH, synchronous, registered full/empty); decode and counters stay in trace_cmd_queue.

Verification
REQ-036 Reset then n=2, address=32'h1234_5678, cmd_ready=1 -> cycle t+1 cmd_valid=1, op OP_IFETCH, tag 12'h123, index 14'h1159, offset 6'h38; instr_reads=1.
REQ-037 cmd_ready=0, five n=0 strobes, DEPTH=4 -> in_ready low after 4th, overflow pulse on 5th, drop_cnt=1, data_reads=4.
REQ-038 Full FIFO, raise cmd_ready -> four entries drain back-to-back in order, cmd_valid falls after 4th, in_ready high after first dequeue.
REQ-039 n=7 strobe -> bad_cmd pulse, drop_cnt=1, FIFO unchanged.
REQ-040 Counters nonzero, n=8 strobe -> all four counters 0 next cycle, OP_CLEAR delivered in order.
REQ-041 Two entries queued, reset asserted with instruction_ready=1 -> next cycle cmd_valid=0, counters 0, nothing enqueued.

Source files
------------

// File: rtl/trace_cmd_queue_pkg.sv
// Shared trace command definitions: op enum, command codes,
// address field widths and the entry layout used by the queue.
package trace_cmd_queue_pkg;

    localparam int ADDR_W   = 32;
    localparam int TAG_W    = 12;
    localparam int INDEX_W  = 14;
    localparam int OFFSET_W = 6;

    localparam logic [31:0] CMD_DREAD  = 32'd0;
    localparam logic [31:0] CMD_DWRITE = 32'd1;
    localparam logic [31:0] CMD_IFETCH = 32'd2;
    localparam logic [31:0] CMD_INVAL  = 32'd3;
    localparam logic [31:0] CMD_SNOOP  = 32'd4;
    localparam logic [31:0] CMD_CLEAR  = 32'd8;
    localparam logic [31:0] CMD_PRINT  = 32'd9;

    typedef enum logic [2:0] {
        OP_DREAD  = 3'd0,
        OP_DWRITE = 3'd1,
        OP_IFETCH = 3'd2,
        OP_INVAL  = 3'd3,
        OP_SNOOP  = 3'd4,
        OP_CLEAR  = 3'd5,
        OP_PRINT  = 3'd6
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ADDR_W-1:0] addr;
        logic              verbose;
    } cmd_t;

    typedef struct packed {
        logic legal;
        op_e  op;
    } dec_t;

    // Maps a raw trace code to an op; unknown codes come back illegal.
    function automatic dec_t decode_cmd(input logic [31:0] code);
        dec_t d;
        d.legal = 1'b1;
        d.op    = OP_DREAD;
        unique case (1'b1)
            (code == CMD_DREAD):  d.op = OP_DREAD;
            (code == CMD_DWRITE): d.op = OP_DWRITE;
            (code == CMD_IFETCH): d.op = OP_IFETCH;
            (code == CMD_INVAL):  d.op = OP_INVAL;
            (code == CMD_SNOOP):  d.op = OP_SNOOP;
            (code == CMD_CLEAR):  d.op = OP_CLEAR;
            (code == CMD_PRINT):  d.op = OP_PRINT;
            default:              d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/trace_cmd_queue_cmd_fifo.sv
// Synchronous FIFO with registered full/empty flags.
// Ports: wr_en_i/wr_data_i push, rd_en_i pop, rd_data_o head, full_o/empty_o.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             full_q;
    logic             empty_q;
    logic             wr;
    logic             rd;

    assign wr = wr_en_i & ~full_q;
    assign rd = rd_en_i & ~empty_q;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({wr, rd})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr) begin
                mem_q[wptr_q] <= wr_data_i;
                wptr_q        <= wptr_q + 1'b1;
            end
            if (rd) begin
                rptr_q <= rptr_q + 1'b1;
            end
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == CW'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    assign rd_data_o = mem_q[rptr_q];
    assign full_o    = full_q;
    assign empty_o   = empty_q;

endmodule

// File: rtl/trace_cmd_queue.sv
// Trace command decoder, queue and statistics front end for the L1 cache.
// Ports: trace record in (instruction_ready/n/address/mode), cmd_* out, stats, error pulses.
module trace_cmd_queue
    import trace_cmd_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                instruction_ready,
    input  logic [31:0]         n,
    input  logic [31:0]         address,
    input  logic [31:0]         mode,
    output logic                in_ready,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output op_e                 cmd_op,
    output logic [TAG_W-1:0]    cmd_tag,
    output logic [INDEX_W-1:0]  cmd_index,
    output logic [OFFSET_W-1:0] cmd_offset,
    output logic                cmd_verbose,
    output logic [CNT_W-1:0]    instr_reads,
    output logic [CNT_W-1:0]    data_reads,
    output logic [CNT_W-1:0]    data_writes,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                bad_cmd,
    output logic                overflow
);

    localparam int EW = $bits(cmd_t);

    dec_t             dec;
    cmd_t             wr_ent;
    cmd_t             head;
    logic [EW-1:0]    head_raw;
    logic             full;
    logic             empty;
    logic             accept;
    logic             bad_d;
    logic             ovf_d;
    logic             bad_q;
    logic             ovf_q;
    logic [CNT_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0] dr_q, dr_d;
    logic [CNT_W-1:0] dw_q, dw_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             unused_mode;

    assign unused_mode = ^mode[31:1];

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    assign dec    = decode_cmd(n);
    assign accept = instruction_ready & in_ready & dec.legal;
    assign bad_d  = instruction_ready & ~dec.legal;
    assign ovf_d  = instruction_ready & dec.legal & ~in_ready;

    assign wr_ent.op      = dec.op;
    assign wr_ent.addr    = address;
    assign wr_ent.verbose = mode[0];

    always_comb begin
        ir_d   = ir_q;
        dr_d   = dr_q;
        dw_d   = dw_q;
        drop_d = drop_q;
        if (accept) begin
            case (dec.op)
                OP_IFETCH: ir_d = sat_inc(ir_q);
                OP_DREAD:  dr_d = sat_inc(dr_q);
                OP_DWRITE: dw_d = sat_inc(dw_q);
                OP_CLEAR: begin
                    ir_d   = '0;
                    dr_d   = '0;
                    dw_d   = '0;
                    drop_d = '0;
                end
                default: ;
            endcase
        end
        if (bad_d | ovf_d) begin
            drop_d = sat_inc(drop_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q   <= '0;
            dr_q   <= '0;
            dw_q   <= '0;
            drop_q <= '0;
            bad_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            ir_q   <= ir_d;
            dr_q   <= dr_d;
            dw_q   <= dw_d;
            drop_q <= drop_d;
            bad_q  <= bad_d;
            ovf_q  <= ovf_d;
        end
    end

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (accept),
        .wr_data_i (wr_ent),
        .rd_en_i   (cmd_valid & cmd_ready),
        .rd_data_o (head_raw),
        .full_o    (full),
        .empty_o   (empty)
    );

    assign head        = cmd_t'(head_raw);
    assign in_ready    = ~full;
    assign cmd_valid   = ~empty;
    assign cmd_op      = head.op;
    assign cmd_tag     = head.addr[31:20];
    assign cmd_index   = head.addr[19:6];
    assign cmd_offset  = head.addr[5:0];
    assign cmd_verbose = head.verbose;
    assign instr_reads = ir_q;
    assign data_reads  = dr_q;
    assign data_writes = dw_q;
    assign drop_cnt    = drop_q;
    assign bad_cmd     = bad_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_trace_cmd_queue.sv
// Scoreboard bench for trace_cmd_queue.
// Expected entries are queued on send and matched on each dequeue.
module tb_trace_cmd_queue;
    import trace_cmd_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                instruction_ready;
    logic [31:0]         n;
    logic [31:0]         address;
    logic [31:0]         mode;
    logic                in_ready;
    logic                cmd_valid;
    logic                cmd_ready;
    op_e                 cmd_op;
    logic [TAG_W-1:0]    cmd_tag;
    logic [INDEX_W-1:0]  cmd_index;
    logic [OFFSET_W-1:0] cmd_offset;
    logic                cmd_verbose;
    logic [CNT_W-1:0]    instr_reads;
    logic [CNT_W-1:0]    data_reads;
    logic [CNT_W-1:0]    data_writes;
    logic [CNT_W-1:0]    drop_cnt;
    logic                bad_cmd;
    logic                overflow;

    int   n_run  = 0;
    int   n_fail = 0;
    cmd_t sb[$];

    trace_cmd_queue #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_ready (instruction_ready),
        .n                 (n),
        .address           (address),
        .mode              (mode),
        .in_ready          (in_ready),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_op            (cmd_op),
        .cmd_tag           (cmd_tag),
        .cmd_index         (cmd_index),
        .cmd_offset        (cmd_offset),
        .cmd_verbose       (cmd_verbose),
        .instr_reads       (instr_reads),
        .data_reads        (data_reads),
        .data_writes       (data_writes),
        .drop_cnt          (drop_cnt),
        .bad_cmd           (bad_cmd),
        .overflow          (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] code, input op_e op,
                        input logic [31:0] a, input logic v,
                        input bit acc);
        cmd_t e;
        if (acc) begin
            e.op      = op;
            e.addr    = a;
            e.verbose = v;
            sb.push_back(e);
        end
        instruction_ready = 1'b1;
        n                 = code;
        address           = a;
        mode              = {31'h2aaa_aaaa, v};
        step();
        instruction_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        cmd_t e;
        if (reset === 1'b0 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            chk("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("hd_op", 64'(cmd_op), 64'(e.op));
                chk("hd_addr", 64'({cmd_tag, cmd_index, cmd_offset}), 64'(e.addr));
                chk("hd_vb", 64'(cmd_verbose), 64'(e.verbose));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog run=%0d fail=%0d", n_run, n_fail);
        $fatal(1);
    end

    initial begin
        reset             = 1'b1;
        instruction_ready = 1'b0;
        n                 = '0;
        address           = '0;
        mode              = '0;
        cmd_ready         = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_valid", 64'(cmd_valid), 0);
        chk("rst_inrdy", 64'(in_ready), 1);
        chk("rst_op", 64'(cmd_op), 64'(OP_DREAD));
        chk("rst_fields", 64'({cmd_tag, cmd_index, cmd_offset, cmd_verbose}), 0);
        chk("rst_cnts", 64'({instr_reads, data_reads, data_writes, drop_cnt}), 0);
        chk("rst_err", 64'({bad_cmd, overflow}), 0);

        cmd_ready = 1'b1;
        send(CMD_IFETCH, OP_IFETCH, 32'h1234_5678, 1'b1, 1);
        chk("if_valid", 64'(cmd_valid), 1);
        chk("if_op", 64'(cmd_op), 64'(OP_IFETCH));
        chk("if_tag", 64'(cmd_tag), 64'h123);
        chk("if_index", 64'(cmd_index), 64'h1159);
        chk("if_offset", 64'(cmd_offset), 64'h38);
        chk("if_ir", 64'(instr_reads), 1);
        step();
        chk("if_drained", 64'(cmd_valid), 0);

        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send(CMD_DREAD, OP_DREAD, 32'hA000_0040 + 32'(i * 64),
                 1'(i), i < 4);
            if (i < 3) chk("fill_inrdy", 64'(in_ready), 1);
            if (i == 3) begin
                chk("full_inrdy", 64'(in_ready), 0);
                chk("full_noovf", 64'(overflow), 0);
                chk("full_head", 64'({cmd_tag, cmd_index, cmd_offset}),
                    64'h A000_0040);
            end
        end
        chk("ovf_pulse", 64'(overflow), 1);
        chk("ovf_drop", 64'(drop_cnt), 1);
        chk("ovf_dr", 64'(data_reads), 4);
        step();
        chk("ovf_clear", 64'(overflow), 0);

        cmd_ready = 1'b1;
        chk("drain_v0", 64'(cmd_valid), 1);
        step();
        chk("drain_inrdy", 64'(in_ready), 1);
        chk("drain_v1", 64'(cmd_valid), 1);
        step();
        step();
        chk("drain_v3", 64'(cmd_valid), 1);
        step();
        chk("drain_end", 64'(cmd_valid), 0);
        chk("drain_sb", 64'(sb.size()), 0);

        cmd_ready = 1'b0;
        send(CMD_DWRITE, OP_DWRITE, 32'h0000_1000, 1'b0, 1);
        chk("pre_dw", 64'(data_writes), 1);
        send(CMD_CLEAR, OP_CLEAR, 32'hDEAD_BEEF, 1'b1, 1);
        chk("clr_cnts", 64'({instr_reads, data_reads, data_writes, drop_cnt}), 0);
        chk("clr_valid", 64'(cmd_valid), 1);
        send(CMD_DREAD, OP_DREAD, 32'h0000_2000, 1'b0, 1);
        chk("post_dr", 64'(data_reads), 1);
        cmd_ready = 1'b1;
        step();
        step();
        step();
        chk("clr_drain", 64'(cmd_valid), 0);

        send(32'd7, OP_DREAD, 32'h5555_0000, 1'b0, 0);
        chk("bad_pulse", 64'(bad_cmd), 1);
        chk("bad_noovf", 64'(overflow), 0);
        chk("bad_drop", 64'(drop_cnt), 1);
        chk("bad_fifo", 64'(cmd_valid), 0);
        chk("bad_dr", 64'(data_reads), 1);
        send(32'h8000_0002, OP_DREAD, 32'h0, 1'b0, 0);
        chk("bad_hi", 64'(drop_cnt), 2);
        send(32'd5, OP_DREAD, 32'h0, 1'b0, 0);
        chk("bad_5", 64'(drop_cnt), 3);
        send(CMD_PRINT, OP_PRINT, 32'hFFFF_FFFF, 1'b1, 1);
        chk("prt_bad", 64'(bad_cmd), 0);
        chk("prt_valid", 64'(cmd_valid), 1);
        step();

        cmd_ready = 1'b0;
        send(CMD_SNOOP, OP_SNOOP, 32'h0000_0100, 1'b0, 1);
        send(CMD_IFETCH, OP_IFETCH, 32'h0000_0200, 1'b1, 1);
        chk("pre_rst_ir", 64'(instr_reads), 1);
        reset             = 1'b1;
        instruction_ready = 1'b1;
        n                 = CMD_IFETCH;
        address           = 32'h0000_0300;
        step();
        reset             = 1'b0;
        instruction_ready = 1'b0;
        sb.delete();
        chk("mrst_valid", 64'(cmd_valid), 0);
        chk("mrst_inrdy", 64'(in_ready), 1);
        chk("mrst_cnts", 64'({instr_reads, data_reads, data_writes, drop_cnt}), 0);
        step();
        chk("mrst_empty", 64'(cmd_valid), 0);

        cmd_ready = 1'b1;
        for (int i = 0; i < 18; i++) begin
            send(CMD_IFETCH, OP_IFETCH, 32'(i) << 6, 1'(i), 1);
        end
        chk("sat_ir", 64'(instr_reads), 15);
        step();
        chk("sat_drain", 64'(cmd_valid), 0);
        chk("sat_sb", 64'(sb.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
